// File: rtl/user.sv
// Serial messaging endpoint: sends a NUM_BYTES text buffer as framed characters, one bit per
// clock, and reassembles the peer's stream. Define PARITY_EN to add an even-parity bit per frame.
module user #(
    parameter int unsigned NUM_BYTES = 100,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [8*NUM_BYTES:1] enter_text_here,
    output logic [8*NUM_BYTES:1] receiving_message_to_file,
    output logic                 out,
    input  logic                 in,
    output logic                 tx_done,
    output logic                 rx_done,
    output logic                 rx_error
);
    localparam int unsigned IDX_W = $clog2(NUM_BYTES + 1);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    // Entry NUM_BYTES-1 is character 0, so the packed layout matches the port layout.
    typedef logic [NUM_BYTES-1:0][DATA_BITS-1:0] msg_t;

    typedef enum logic [2:0] {
        TxIdle, TxLoad, TxStart, TxData, TxParity, TxStop, TxDone
    } tx_state_e;

    typedef enum logic [1:0] {
        RxWait, RxData, RxParity, RxStop
    } rx_state_e;

    tx_state_e            tx_state_q, tx_state_d;
    msg_t                 shadow_q, shadow_d;
    logic [IDX_W-1:0]     tx_index_q, tx_index_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_char;

    rx_state_e            rx_state_q, rx_state_d;
    msg_t                 rx_buf_q, rx_buf_d;
    logic [IDX_W-1:0]     rx_index_q, rx_index_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_ok_q, rx_par_ok_d;
    logic                 rx_done_q, rx_done_d;
    logic                 rx_error_q, rx_error_d;

    assign tx_char = shadow_q[LAST_IDX - tx_index_q];

    always_comb begin
        tx_state_d = tx_state_q;
        shadow_d   = shadow_q;
        tx_index_d = tx_index_q;
        tx_bit_d   = tx_bit_q;
        out        = 1'b1;
        tx_done    = 1'b0;
        unique case (tx_state_q)
            TxIdle: tx_state_d = TxLoad;
            TxLoad: begin
                shadow_d   = enter_text_here;
                tx_index_d = '0;
                tx_state_d = TxStart;
            end
            TxStart: begin
                out        = 1'b0;
                tx_bit_d   = LAST_BIT;
                tx_state_d = TxData;
            end
            TxData: begin
                out = tx_char[tx_bit_q];
                if (tx_bit_q == '0) begin
`ifdef PARITY_EN
                    tx_state_d = TxParity;
`else
                    tx_state_d = TxStop;
`endif
                end else begin
                    tx_bit_d = tx_bit_q - BIT_W'(1);
                end
            end
            TxParity: begin
                out        = ^tx_char;
                tx_state_d = TxStop;
            end
            TxStop: begin
                if (tx_index_q == LAST_IDX) begin
                    tx_state_d = TxDone;
                end else begin
                    tx_index_d = tx_index_q + IDX_W'(1);
                    tx_state_d = TxStart;
                end
            end
            TxDone: begin
                tx_done = 1'b1;
                if (enter_text_here != shadow_q) tx_state_d = TxLoad;
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_buf_d    = rx_buf_q;
        rx_index_d  = rx_index_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_ok_d = rx_par_ok_q;
        rx_done_d   = rx_done_q;
        rx_error_d  = rx_error_q;
        unique case (rx_state_q)
            RxWait: begin
                if (!in) begin
                    rx_state_d  = RxData;
                    rx_bit_d    = LAST_BIT;
                    rx_par_ok_d = 1'b1;
                    // A start bit after a complete message begins a fresh one.
                    if (rx_done_q) begin
                        rx_buf_d   = '0;
                        rx_index_d = '0;
                        rx_done_d  = 1'b0;
                        rx_error_d = 1'b0;
                    end
                end
            end
            RxData: begin
                rx_shift_d = {rx_shift_q[DATA_BITS-2:0], in};
                if (rx_bit_q == '0) begin
`ifdef PARITY_EN
                    rx_state_d = RxParity;
`else
                    rx_state_d = RxStop;
`endif
                end else begin
                    rx_bit_d = rx_bit_q - BIT_W'(1);
                end
            end
            RxParity: begin
                rx_par_ok_d = ((^rx_shift_q) == in);
                rx_state_d  = RxStop;
            end
            RxStop: begin
                rx_state_d = RxWait;
                if (in && rx_par_ok_q) begin
                    rx_buf_d[LAST_IDX - rx_index_q] = rx_shift_q;
                    rx_index_d = rx_index_q + IDX_W'(1);
                    if (rx_index_q == LAST_IDX) rx_done_d = 1'b1;
                end else begin
                    rx_error_d = 1'b1;
                end
            end
            default: rx_state_d = RxWait;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q  <= TxIdle;
            shadow_q    <= '0;
            tx_index_q  <= '0;
            tx_bit_q    <= '0;
            rx_state_q  <= RxWait;
            rx_buf_q    <= '0;
            rx_index_q  <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_ok_q <= 1'b1;
            rx_done_q   <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            shadow_q    <= shadow_d;
            tx_index_q  <= tx_index_d;
            tx_bit_q    <= tx_bit_d;
            rx_state_q  <= rx_state_d;
            rx_buf_q    <= rx_buf_d;
            rx_index_q  <= rx_index_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_ok_q <= rx_par_ok_d;
            rx_done_q   <= rx_done_d;
            rx_error_q  <= rx_error_d;
        end
    end

    assign receiving_message_to_file = rx_buf_q;
    assign rx_done                   = rx_done_q;
    assign rx_error                  = rx_error_q;

endmodule

// File: tb/tb_user.sv
// Bench for user: two cross-connected endpoints checked every cycle against a frame-level
// model, plus a third endpoint whose receive line is driven directly with good and bad frames.
module tb_user;
    localparam int N = 100;
    localparam int W = 8 * N;
`ifdef PARITY_EN
    localparam int FRAME = 11;
    localparam int MAXK  = 2;
    localparam logic [0:FRAME-1] LIT41 = 11'b00100000101;
`else
    localparam int FRAME = 10;
    localparam int MAXK  = 1;
    localparam logic [0:FRAME-1] LIT41 = 10'b0010000011;
`endif
    localparam int TOTAL = 2 + FRAME * N;

    localparam logic [W:1] MSG_HELLO = {{(W-40){1'b0}}, "HELLO"};
    localparam logic [W:1] MSG_WORLD = {{(W-40){1'b0}}, "WORLD"};
    localparam logic [W:1] MSG_BYE   = {{(W-24){1'b0}}, "BYE"};

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic [W:1] a_text, b_text, c_text, a_rx, b_rx, c_rx;
    logic a_out, b_out, c_out, c_in;
    logic a_txd, a_rxd, a_err, b_txd, b_rxd, b_err, c_txd, c_rxd, c_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    always #5 clock = ~clock;

    user #(.NUM_BYTES(N), .DATA_BITS(8)) u_a (
        .clock(clock), .reset_n(reset_n), .enter_text_here(a_text),
        .receiving_message_to_file(a_rx), .out(a_out), .in(b_out),
        .tx_done(a_txd), .rx_done(a_rxd), .rx_error(a_err)
    );
    user #(.NUM_BYTES(N), .DATA_BITS(8)) u_b (
        .clock(clock), .reset_n(reset_n), .enter_text_here(b_text),
        .receiving_message_to_file(b_rx), .out(b_out), .in(a_out),
        .tx_done(b_txd), .rx_done(b_rxd), .rx_error(b_err)
    );
    user #(.NUM_BYTES(N), .DATA_BITS(8)) u_c (
        .clock(clock), .reset_n(reset_n), .enter_text_here(c_text),
        .receiving_message_to_file(c_rx), .out(c_out), .in(c_in),
        .tx_done(c_txd), .rx_done(c_rxd), .rx_error(c_err)
    );

    // Cycles since reset release; cycle 0 is the first cycle after release.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [W:1] act, input logic [W:1] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Line level on cycle rel of a transmission that started (IDLE or DONE) at rel 0.
    function automatic logic exp_bit(input logic [W:1] msg, input int rel);
        int j, b;
        logic [7:0] ch;
        if (rel < 2 || rel >= TOTAL) return 1'b1;
        j  = (rel - 2) / FRAME;
        b  = (rel - 2) % FRAME;
        ch = 8'(msg >> (8 * (N - 1 - j)));
        if (b == 0) return 1'b0;
        if (b <= 8) return ch[3'(8 - b)];
        if (b == FRAME - 1) return 1'b1;
        return ^ch;
    endfunction

    function automatic logic [W:1] prefix(input logic [W:1] msg, input int n);
        if (n <= 0) return '0;
        if (n >= N) return msg;
        return msg & ~({W{1'b1}} >> (8 * n));
    endfunction

    // Link model: index 0 is A->B, 1 is B->A.
    int         s  [2];
    logic [W:1] m  [2];
    logic [W:1] pm [2];
    bit         pv [2];

    function automatic logic [W:1] text_of(input int i);
        return (i == 0) ? a_text : b_text;
    endfunction

    initial begin
        int rel;
        logic [W:1] rx_exp;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                check("rst_a_out", a_out, 1);
                check("rst_b_out", b_out, 1);
                check("rst_c_out", c_out, 1);
                check("rst_flags", {a_txd, a_rxd, a_err, b_txd, b_rxd, b_err, c_txd, c_rxd, c_err}, 0);
                check("rst_a_rx", a_rx, '0);
                check("rst_b_rx", b_rx, '0);
                check("rst_c_rx", c_rx, '0);
                for (int i = 0; i < 2; i++) begin
                    s[i] = 0; pv[i] = 0; pm[i] = '0; m[i] = '0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    rel = cyc - s[i];
                    if (rel < 3) rx_exp = pv[i] ? pm[i] : '0;
                    else         rx_exp = prefix(m[i], (rel - 2) / FRAME);
                    check($sformatf("out%0d@%0d", i, cyc), (i == 0) ? a_out : b_out,
                          exp_bit(m[i], rel));
                    check($sformatf("txdone%0d@%0d", i, cyc), (i == 0) ? a_txd : b_txd,
                          rel >= TOTAL);
                    check($sformatf("rxbuf%0d@%0d", i, cyc), (i == 0) ? b_rx : a_rx, rx_exp);
                    check($sformatf("rxdone%0d@%0d", i, cyc), (i == 0) ? b_rxd : a_rxd,
                          (rel >= TOTAL) || (rel < 3 && pv[i]));
                    check($sformatf("rxerr%0d@%0d", i, cyc), (i == 0) ? b_err : a_err, 0);
                    if (rel == 1) m[i] = text_of(i);
                    else if (rel >= TOTAL && text_of(i) != m[i]) begin
                        pm[i] = m[i];
                        pv[i] = 1'b1;
                        s[i]  = cyc;
                    end
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        c_in = b;
        @(posedge clock);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] ch, input bit bad_stop, input bit flip);
        logic [7:0] d;
        d = ch;
        if (flip) d = ch ^ (8'h01 << $urandom_range(0, 7));
        drive_bit(1'b0);
        for (int k = 0; k < 8; k++) begin
            drive_bit(d[7]);
            d = d << 1;
        end
`ifdef PARITY_EN
        drive_bit(^ch);
`endif
        drive_bit(!bad_stop);
        c_in = 1'b1;
    endtask

    function automatic logic [W:1] rand_buf();
        logic [W:1] r;
        r = '0;
        for (int k = 0; k < W / 32; k++) r = (r << 32) | W'($urandom());
        return r;
    endfunction

    initial begin
        a_text = MSG_HELLO;
        b_text = MSG_WORLD;
        c_text = {8'h41, {(W-8){1'b0}}};
        c_in   = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;

        fork
            begin
                for (int t = 0; t < 2 + FRAME; t++) begin
                    @(negedge clock);
                    if (t >= 2) check($sformatf("c_frame_bit%0d", t - 2), c_out, LIT41[t-2]);
                end
            end
            begin
                logic [W:1] c_exp, lit;
                int c_idx, kind;
                bit c_e;
                logic [7:0] ch;
                c_exp = '0; c_idx = 0; c_e = 0;
                for (int f = 0; f < 13; f++) begin
                    if (f == 0)      begin ch = 8'h5A; kind = 0; end
                    else if (f == 1) begin ch = 8'h33; kind = 1; end
                    else if (f == 2) begin ch = 8'hC3; kind = 0; end
                    else begin ch = 8'($urandom()); kind = $urandom_range(0, MAXK); end
                    send_frame(ch, kind == 1, kind == 2);
                    if (kind == 0) begin
                        c_exp = c_exp | (W'(ch) << (8 * (N - 1 - c_idx)));
                        c_idx++;
                    end else begin
                        c_e = 1'b1;
                    end
                    @(negedge clock);
                    check($sformatf("c_rxbuf_f%0d", f), c_rx, c_exp);
                    check($sformatf("c_rxerr_f%0d", f), c_err, c_e);
                    check($sformatf("c_rxdone_f%0d", f), c_rxd, 0);
                    if (f == 2) begin
                        lit = '0;
                        lit[W -: 16] = 16'h5AC3;
                        check("c_slot_reuse", c_rx, lit);
                        check("c_err_sticky", c_err, 1);
                    end
                    @(posedge clock);
                    #2;
                    repeat ($urandom_range(0, 3)) drive_bit(1'b1);
                end
            end
            begin
                for (int t = 0; t <= TOTAL; t++) @(negedge clock);
                check("loop_a_rx", a_rx, MSG_WORLD);
                check("loop_b_rx", b_rx, MSG_HELLO);
                check("loop_done", {a_txd, a_rxd, b_txd, b_rxd}, 4'hF);
                check("loop_err", {a_err, b_err}, 0);
            end
        join

        @(posedge clock);
        #2 a_text = MSG_BYE;
        repeat (TOTAL + 4) @(negedge clock);
        check("bye_b_rx", b_rx, MSG_BYE);
        check("bye_done", {a_txd, b_rxd}, 2'b11);

        @(posedge clock);
        #2;
        a_text = rand_buf();
        b_text = rand_buf();
        repeat (500) @(posedge clock);
        #2 reset_n = 1'b0;
        @(negedge clock);
        check("mid_rst_out", {a_out, b_out}, 2'b11);
        check("mid_rst_bufs", a_rx | b_rx, '0);
        check("mid_rst_done", {a_txd, a_rxd, b_txd, b_rxd}, 0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (TOTAL + 3) @(negedge clock);
        check("rand_a_rx", a_rx, b_text);
        check("rand_b_rx", b_rx, a_text);
        check("rand_done", {a_txd, a_rxd, b_txd, b_rxd}, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
